// File: rtl/jtopl_mmrx.sv
// jtopl_mmrx: CPU register front end for OPL/OPL2/OPL3.
// Latches address/data writes, decodes update strobes and globals, and tracks the busy window.
module jtopl_mmrx #(
    parameter int OPL_TYPE = 1,
    parameter int BANKS    = 1,
    parameter int BUSY_A   = 12,
    parameter int BUSY_D   = 84
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic [7:0] din,
    input  logic [1:0] addr,
    input  logic       write,
    output logic       busy,
    output logic [7:0] din_copy,
    output logic       sel_bank,
    output logic [1:0] sel_group,
    output logic [2:0] sel_sub,
    output logic       up_mult,
    output logic       up_ksl_tl,
    output logic       up_ar_dr,
    output logic       up_sl_rr,
    output logic       up_wav,
    output logic       up_fnumlo,
    output logic       up_fnumhi,
    output logic       up_fbcon,
    output logic [7:0] value_A,
    output logic [7:0] value_B,
    output logic       load_A,
    output logic       load_B,
    output logic       flagen_A,
    output logic       flagen_B,
    output logic       clr_flag_A,
    output logic       clr_flag_B,
    output logic       am_dep,
    output logic       vib_dep,
    output logic       rhy_en,
    output logic [4:0] rhy_kon,
    output logic       wave_mode,
    output logic       csm_en,
    output logic       note_sel,
    output logic       new_mode,
    output logic [5:0] con4op
);
    localparam logic [6:0] LD_A = 7'(BUSY_A);
    localparam logic [6:0] LD_D = 7'(BUSY_D);
    logic [7:0] selreg;
    logic       selbank;
    logic [6:0] cnt;
    logic [3:0] ch;
    logic       awr, dwr, sl_en, op_ok, ch_ok;
    assign busy = |cnt;
    assign ch   = selreg[3:0];
    // Bank-1 slot/channel registers only exist once NEW mode is on
    always_comb begin
        awr   = write && !addr[0];
        dwr   = write && addr[0];
        sl_en = !selbank || new_mode;
        op_ok = sl_en && ((selreg >= 8'h20 && selreg < 8'hA0) || (OPL_TYPE > 1 && selreg >= 8'hE0))
                && selreg[2:0] <= 3'd5 && selreg[4:3] != 2'd3;
        ch_ok = sl_en && selreg >= 8'hA0 && selreg <= 8'hC8 && ch <= 4'd8;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            selreg     <= 8'd0;
            selbank    <= 1'b0;
            cnt        <= 7'd0;
            din_copy   <= 8'd0;
            sel_bank   <= 1'b0;
            sel_group  <= 2'd0;
            sel_sub    <= 3'd0;
            up_mult    <= 1'b0;
            up_ksl_tl  <= 1'b0;
            up_ar_dr   <= 1'b0;
            up_sl_rr   <= 1'b0;
            up_wav     <= 1'b0;
            up_fnumlo  <= 1'b0;
            up_fnumhi  <= 1'b0;
            up_fbcon   <= 1'b0;
            value_A    <= 8'd0;
            value_B    <= 8'd0;
            load_A     <= 1'b0;
            load_B     <= 1'b0;
            flagen_A   <= 1'b1;
            flagen_B   <= 1'b1;
            clr_flag_A <= 1'b0;
            clr_flag_B <= 1'b0;
            am_dep     <= 1'b0;
            vib_dep    <= 1'b0;
            rhy_en     <= 1'b0;
            rhy_kon    <= 5'd0;
            wave_mode  <= 1'b0;
            csm_en     <= 1'b0;
            note_sel   <= 1'b0;
            new_mode   <= 1'b0;
            con4op     <= 6'd0;
        end else begin
            if (awr) begin
                selreg  <= din;
                selbank <= BANKS == 2 ? addr[1] : 1'b0;
            end
            if (write)
                cnt <= awr ? LD_A : LD_D;
            else if (cen && busy)
                cnt <= cnt - 7'd1;
            if (cen && !write) begin
                {up_mult, up_ksl_tl, up_ar_dr, up_sl_rr} <= 4'd0;
                {up_wav, up_fnumlo, up_fnumhi, up_fbcon} <= 4'd0;
                {clr_flag_A, clr_flag_B} <= 2'd0;
            end
            if (dwr) begin
                din_copy  <= din;
                up_mult   <= op_ok && selreg[7:5] == 3'd1;
                up_ksl_tl <= op_ok && selreg[7:5] == 3'd2;
                up_ar_dr  <= op_ok && selreg[7:5] == 3'd3;
                up_sl_rr  <= op_ok && selreg[7:5] == 3'd4;
                up_wav    <= OPL_TYPE > 1 && op_ok && selreg[7:5] == 3'd7;
                up_fnumlo <= ch_ok && selreg[7:4] == 4'hA;
                up_fnumhi <= ch_ok && selreg[7:4] == 4'hB;
                up_fbcon  <= ch_ok && selreg[7:4] == 4'hC;
                if (op_ok) begin
                    sel_group <= selreg[4:3];
                    sel_sub   <= selreg[2:0];
                    sel_bank  <= selbank;
                end
                if (ch_ok) begin
                    sel_group <= ch < 4'd3 ? 2'd0 : ch < 4'd6 ? 2'd1 : 2'd2;
                    sel_sub   <= ch >= 4'd6 ? ch[2:0] - 3'd6 : ch[2:0];
                    sel_bank  <= selbank;
                end
                if (!selbank) begin
                    if (selreg == 8'h01 && OPL_TYPE > 1) wave_mode <= din[5];
                    if (selreg == 8'h02) value_A <= din;
                    if (selreg == 8'h03) value_B <= din;
                    if (selreg == 8'h04) begin
                        clr_flag_A <= din[7] | din[6];
                        clr_flag_B <= din[7] | din[5];
                        if (!din[7]) begin
                            flagen_A         <= ~din[6];
                            flagen_B         <= ~din[5];
                            {load_B, load_A} <= din[1:0];
                        end
                    end
                    if (selreg == 8'h08) {csm_en, note_sel} <= din[7:6];
                    if (selreg == 8'hBD) {am_dep, vib_dep, rhy_en, rhy_kon} <= din;
                end else begin
                    if (selreg == 8'h05) new_mode <= din[0];
                    if (selreg == 8'h04 && new_mode) con4op <= din[5:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_jtopl_mmrx.sv
// tb_jtopl_mmrx: directed vectors for the OPL3 two-bank register front end.
module tb_jtopl_mmrx;
    logic       clk = 1'b0, rst = 1'b1, cen = 1'b0, write = 1'b0;
    logic [7:0] din = 8'd0;
    logic [1:0] addr = 2'd0;
    logic       busy, sel_bank, up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav;
    logic       up_fnumlo, up_fnumhi, up_fbcon, load_A, load_B, flagen_A, flagen_B;
    logic       clr_flag_A, clr_flag_B, am_dep, vib_dep, rhy_en, wave_mode, csm_en;
    logic       note_sel, new_mode;
    logic [7:0] din_copy, value_A, value_B;
    logic [1:0] sel_group;
    logic [2:0] sel_sub;
    logic [4:0] rhy_kon;
    logic [5:0] con4op;
    logic [7:0] ups;
    int nvec = 0, nerr = 0;
    assign ups = {up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav, up_fnumlo, up_fnumhi, up_fbcon};
    always #5 clk = ~clk;
    jtopl_mmrx #(.OPL_TYPE(3), .BANKS(2), .BUSY_A(12), .BUSY_D(84)) dut (
        .clk(clk), .rst(rst), .cen(cen), .din(din), .addr(addr), .write(write),
        .busy(busy), .din_copy(din_copy), .sel_bank(sel_bank), .sel_group(sel_group),
        .sel_sub(sel_sub), .up_mult(up_mult), .up_ksl_tl(up_ksl_tl), .up_ar_dr(up_ar_dr),
        .up_sl_rr(up_sl_rr), .up_wav(up_wav), .up_fnumlo(up_fnumlo), .up_fnumhi(up_fnumhi),
        .up_fbcon(up_fbcon), .value_A(value_A), .value_B(value_B), .load_A(load_A),
        .load_B(load_B), .flagen_A(flagen_A), .flagen_B(flagen_B), .clr_flag_A(clr_flag_A),
        .clr_flag_B(clr_flag_B), .am_dep(am_dep), .vib_dep(vib_dep), .rhy_en(rhy_en),
        .rhy_kon(rhy_kon), .wave_mode(wave_mode), .csm_en(csm_en), .note_sel(note_sel),
        .new_mode(new_mode), .con4op(con4op)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic wr(input logic [1:0] a, input logic [7:0] d, input logic c);
        addr = a; din = d; write = 1'b1; cen = c;
        @(posedge clk); #1;
        write = 1'b0; cen = 1'b0;
    endtask
    task automatic idle(input logic c);
        cen = c;
        @(posedge clk); #1;
        cen = 1'b0;
    endtask
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            idle(1'b1);
            repeat (3) idle(1'b0);
        end
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_flagen", {flagen_A, flagen_B}, 2'b11);
        chk("rst_busy", busy, 0);
        chk("rst_zero", {din_copy, sel_bank, sel_group, sel_sub, ups, value_A, value_B, load_A, load_B,
                         clr_flag_A, clr_flag_B, am_dep, vib_dep, rhy_en, rhy_kon, wave_mode,
                         csm_en, note_sel, new_mode, con4op}, 0);
        // operator write and strobe lifetime
        wr(2'd0, 8'h48, 1'b0);
        wr(2'd1, 8'h3F, 1'b0);
        chk("op_ups", ups, 8'b0100_0000);
        chk("op_sel", {sel_bank, sel_group, sel_sub}, {1'b0, 2'd1, 3'd0});
        chk("op_din", din_copy, 8'h3F);
        chk("op_busy", busy, 1);
        idle(1'b0);
        chk("op_hold", ups, 8'b0100_0000);
        wr(2'd0, 8'h20, 1'b1);
        chk("op_wr_wins", ups, 8'b0100_0000);
        idle(1'b1);
        chk("op_clear", ups, 0);
        // channel writes, valid and invalid
        wr(2'd0, 8'hB7, 1'b0);
        wr(2'd1, 8'h31, 1'b0);
        chk("ch_ups", ups, 8'b0000_0010);
        chk("ch_sel", {sel_group, sel_sub}, {2'd2, 3'd1});
        wr(2'd0, 8'hA9, 1'b0);
        wr(2'd1, 8'h55, 1'b0);
        chk("a9_ups", ups, 0);
        chk("a9_sel", {sel_group, sel_sub}, {2'd2, 3'd1});
        chk("a9_din", din_copy, 8'h55);
        wr(2'd0, 8'h36, 1'b0);
        wr(2'd1, 8'h12, 1'b0);
        chk("36_ups", ups, 0);
        chk("36_sel", {sel_group, sel_sub}, {2'd2, 3'd1});
        wr(2'd0, 8'hC8, 1'b0);
        wr(2'd1, 8'h01, 1'b0);
        chk("c8_ups", ups, 8'b0000_0001);
        chk("c8_sel", {sel_group, sel_sub}, {2'd2, 3'd2});
        wr(2'd0, 8'hF5, 1'b0);
        wr(2'd1, 8'h02, 1'b0);
        chk("f5_ups", ups, 8'b0000_1000);
        chk("f5_sel", {sel_group, sel_sub}, {2'd2, 3'd5});
        // bank 1
        wr(2'd2, 8'h04, 1'b0);
        wr(2'd3, 8'h3F, 1'b0);
        chk("b1_con_locked", con4op, 0);
        wr(2'd2, 8'hA0, 1'b0);
        wr(2'd3, 8'h11, 1'b0);
        chk("b1_slot_locked", {sel_bank, ups}, 0);
        wr(2'd2, 8'h05, 1'b0);
        wr(2'd3, 8'h01, 1'b0);
        chk("b1_new", new_mode, 1);
        wr(2'd2, 8'h04, 1'b0);
        wr(2'd3, 8'h3F, 1'b0);
        chk("b1_con", con4op, 6'h3F);
        wr(2'd2, 8'hA0, 1'b0);
        wr(2'd1, 8'h22, 1'b0);
        chk("b1_ups", ups, 8'b0000_0100);
        chk("b1_sel", {sel_bank, sel_group, sel_sub}, {1'b1, 2'd0, 3'd0});
        // bank 0 globals
        wr(2'd0, 8'h04, 1'b0);
        wr(2'd1, 8'h80, 1'b0);
        chk("t80", {clr_flag_A, clr_flag_B, flagen_A, flagen_B, load_A, load_B}, 6'b111100);
        wr(2'd0, 8'h04, 1'b0);
        wr(2'd1, 8'h43, 1'b0);
        chk("t43", {clr_flag_A, clr_flag_B, flagen_A, flagen_B, load_A, load_B}, 6'b100111);
        idle(1'b1);
        chk("t_clr", {clr_flag_A, clr_flag_B, flagen_A, flagen_B, load_A, load_B}, 6'b000111);
        wr(2'd0, 8'h02, 1'b0);
        wr(2'd1, 8'h9C, 1'b0);
        wr(2'd0, 8'h03, 1'b0);
        wr(2'd1, 8'h61, 1'b0);
        chk("values", {value_A, value_B}, 16'h9C61);
        wr(2'd0, 8'hBD, 1'b0);
        wr(2'd1, 8'hE5, 1'b0);
        chk("bd", {am_dep, vib_dep, rhy_en, rhy_kon}, 8'hE5);
        wr(2'd0, 8'h08, 1'b0);
        wr(2'd1, 8'hC0, 1'b0);
        wr(2'd0, 8'h01, 1'b0);
        wr(2'd1, 8'h20, 1'b0);
        chk("modes", {csm_en, note_sel, wave_mode}, 3'b111);
        // busy timing
        ticks(90);
        chk("busy_idle", busy, 0);
        wr(2'd1, 8'h00, 1'b0);
        ticks(83);
        chk("busy_d83", busy, 1);
        ticks(1);
        chk("busy_d84", busy, 0);
        wr(2'd0, 8'h00, 1'b1);
        ticks(11);
        chk("busy_a11", busy, 1);
        ticks(1);
        chk("busy_a12", busy, 0);
        wr(2'd1, 8'h00, 1'b0);
        ticks(40);
        wr(2'd1, 8'h00, 1'b0);
        ticks(83);
        chk("busy_rl83", busy, 1);
        ticks(1);
        chk("busy_rl84", busy, 0);
        wr(2'd1, 8'h77, 1'b0);
        ticks(10);
        rst = 1'b1;
        #1;
        chk("rst_async", {busy, din_copy, flagen_A}, {1'b0, 8'h00, 1'b1});
        @(posedge clk); #1 rst = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
